// File: rtl/dunit_loader_stepper.sv
// Byte-command debug controller for the pipeline's debug-unit port.
// It loads instruction memory from a host byte stream and runs the pipeline
// by single step, N steps, run-to-halt, or PC reset. It also counts gated cycles.
module dunit_loader_stepper #(
    parameter int unsigned NB_REG     = 32,
    parameter int unsigned NB_BYTE    = 8,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned NB_STEP    = 16,
    parameter int unsigned NB_CYC     = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if,
    output logic [NB_CYC-1:0]  o_cycle_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    // Counts arrive as two host bytes, low byte first.
    localparam int unsigned NbCnt        = 2 * NB_BYTE;
    localparam int unsigned BytesPerWord = NB_REG / NB_BYTE;
    localparam int unsigned SelW         = $clog2(BytesPerWord);
    localparam logic [NbCnt:0]  MaxWords = (NbCnt + 1)'(IMEM_DEPTH);
    localparam logic [SelW-1:0] LastSel  = SelW'(BytesPerWord - 1);

    localparam logic [NB_BYTE-1:0] CmdLoad  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CmdStep  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CmdNStep = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CmdRun   = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CmdRstPc = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CmdAbort = NB_BYTE'(8'h58);

    typedef enum logic [3:0] {
        StIdle,
        StLdCnt0,
        StLdCnt1,
        StLdByte,
        StLdWrite,
        StStCnt0,
        StStCnt1,
        StStep,
        StRun,
        StRstPc,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [NB_BYTE-1:0]  cnt_lo_q, cnt_lo_d;
    logic [NbCnt-1:0]    count_q, count_d;
    logic [NbCnt-1:0]    idx_q, idx_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic [NB_REG-1:0]   word_q, word_d;
    logic [NB_REG-1:0]   addr_q, addr_d;
    logic [NB_REG-1:0]   data_q, data_d;
    logic [NB_STEP-1:0]  rem_q, rem_d;
    logic [NB_CYC-1:0]   cyc_q, cyc_d;
    logic                err_q, err_d;

    logic                rx_ready;
    logic                clk_en;
    logic                accept;
    logic [NbCnt-1:0]    cnt_word;
    logic [NB_REG-1:0]   word_shift;

    assign accept     = i_rx_valid & rx_ready;
    assign cnt_word   = {i_rx_data, cnt_lo_q};
    // Shift in from the top so the first byte of a word ends up in bits [7:0].
    assign word_shift = {i_rx_data, word_q[NB_REG-1:NB_BYTE]};

    // State-decoded outputs and the pipeline clock enable.
    always_comb begin
        rx_ready         = 1'b0;
        clk_en           = 1'b0;
        o_dunit_w_mem    = 1'b0;
        o_dunit_reset_pc = 1'b0;
        o_done           = 1'b0;
        case (state_q)
            StIdle, StLdCnt0, StLdCnt1, StLdByte, StStCnt0, StStCnt1: rx_ready = 1'b1;
            StRun: begin
                rx_ready = 1'b1;
                clk_en   = ~i_halt;
            end
            StStep:    clk_en           = (rem_q != '0) & ~i_halt;
            StLdWrite: o_dunit_w_mem    = 1'b1;
            StRstPc:   o_dunit_reset_pc = 1'b1;
            StFin:     o_done           = 1'b1;
            default: ;
        endcase
    end

    // Command decode, load/step sequencing and the saturating cycle counter.
    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        count_d  = count_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        word_d   = word_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rem_d    = rem_q;
        cyc_d    = cyc_q;
        err_d    = 1'b0;

        if (clk_en && (cyc_q != '1)) begin
            cyc_d = cyc_q + NB_CYC'(1);
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (i_rx_data)
                        CmdLoad:  state_d = StLdCnt0;
                        CmdNStep: state_d = StStCnt0;
                        CmdRun:   state_d = StRun;
                        CmdRstPc: state_d = StRstPc;
                        CmdStep: begin
                            state_d = StStep;
                            rem_d   = NB_STEP'(1);
                        end
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            StLdCnt0, StStCnt0: begin
                if (accept) begin
                    cnt_lo_d = i_rx_data;
                    state_d  = (state_q == StLdCnt0) ? StLdCnt1 : StStCnt1;
                end
            end
            StLdCnt1: begin
                if (accept) begin
                    if (cnt_word == '0) begin
                        state_d = StFin;
                    end else if ({1'b0, cnt_word} > MaxWords) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        count_d = cnt_word;
                        idx_d   = '0;
                        sel_d   = '0;
                        word_d  = '0;
                        state_d = StLdByte;
                    end
                end
            end
            StLdByte: begin
                if (accept) begin
                    word_d = word_shift;
                    if (sel_q == LastSel) begin
                        sel_d   = '0;
                        data_d  = word_shift;
                        addr_d  = NB_REG'(idx_q) << SelW;
                        state_d = StLdWrite;
                    end else begin
                        sel_d = sel_q + SelW'(1);
                    end
                end
            end
            StLdWrite: begin
                idx_d   = idx_q + NbCnt'(1);
                state_d = (idx_q == count_q - NbCnt'(1)) ? StFin : StLdByte;
            end
            StStCnt1: begin
                if (accept) begin
                    if (cnt_word == '0) begin
                        state_d = StFin;
                    end else begin
                        rem_d   = NB_STEP'(cnt_word);
                        state_d = StStep;
                    end
                end
            end
            StStep: begin
                if (clk_en) begin
                    rem_d = rem_q - NB_STEP'(1);
                end
                if (i_halt || (rem_q == '0) || (clk_en && (rem_q == NB_STEP'(1)))) begin
                    state_d = StFin;
                end
            end
            StRun: begin
                // The cycle that accepts the abort byte still runs; enable drops after.
                if (i_halt || (accept && (i_rx_data == CmdAbort))) begin
                    state_d = StFin;
                end
            end
            StRstPc: begin
                cyc_d   = '0;
                state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= StIdle;
            cnt_lo_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            sel_q    <= '0;
            word_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rem_q    <= '0;
            cyc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
        end
    end

    assign o_rx_ready      = rx_ready;
    assign o_dunit_clk_en  = clk_en;
    assign o_dunit_addr    = addr_q;
    assign o_dunit_data_if = data_q;
    assign o_cycle_count   = cyc_q;
    assign o_busy          = (state_q != StIdle);
    assign o_err           = err_q;

endmodule

// File: doc/dunit_loader_stepper.md
Name: dunit_loader_stepper

Overview:
Byte-command debug controller that drives the pipeline's debug-unit interface (clock enable, PC reset, instruction-memory write port). It receives a host byte stream, loads programs into instruction memory, and executes them in one of four modes: single step, N-step, run-to-halt, or PC reset. It also keeps a gated-cycle counter. It sits between the UART receiver and the pipeline's i_dunit_* inputs.

Parameters:
NB_REG, 32, instruction/data/address width
NB_BYTE, 8, host stream byte width
IMEM_DEPTH, 256, instruction memory depth in words (maximum load count)
NB_STEP, 16, width of the N-step count
NB_CYC, 32, width of the cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_rx_data  in  NB_BYTE  host byte
i_rx_valid  in  1  byte valid; accepted when i_rx_valid & o_rx_ready
o_rx_ready  out  1  controller can accept a byte
i_halt  in  1  pipeline halt reached (level)
o_dunit_clk_en  out  1  pipeline clock enable
o_dunit_reset_pc  out  1  PC reset pulse
o_dunit_w_mem  out  1  instruction-memory write strobe
o_dunit_addr  out  NB_REG  instruction-memory byte address
o_dunit_data_if  out  NB_REG  instruction word
o_cycle_count  out  NB_CYC  pipeline cycles executed
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse when a command completes
o_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (asynchronous, any state): all outputs 0 except o_rx_ready=1. State goes to IDLE; counters, index and word register are cleared.
- States: IDLE, LD_CNT0, LD_CNT1, LD_BYTE, LD_WRITE, ST_CNT0, ST_CNT1, STEP, RUN, RST_PC, FIN.
- o_rx_ready=1 in IDLE, LD_CNT0/1, LD_BYTE, ST_CNT0/1, RUN. It is 0 otherwise.
- Commands, decoded in IDLE:
  - 0x4C 'L': go to LD_CNT0.
  - 0x53 'S': go to STEP with remaining=1.
  - 0x4E 'N': go to ST_CNT0.
  - 0x43 'C': go to RUN.
  - 0x52 'R': go to RST_PC.
  - Any other byte: o_err pulse; stay in IDLE.
- Load sequence:
  - Two count bytes, low byte first, give word count W.
  - W=0: go to FIN with no writes.
  - W>IMEM_DEPTH: o_err pulse, return to IDLE, no writes.
  - Otherwise collect 4 bytes per word, little-endian (first byte goes to bits [7:0]).
  - The cycle after the 4th byte: LD_WRITE asserts o_dunit_w_mem for exactly one cycle, with o_dunit_addr=index*4 and o_dunit_data_if=word. Then index increments.
  - After write W-1: go to FIN. Otherwise return to LD_BYTE.
  - o_dunit_addr and o_dunit_data_if hold their last values when not writing.
- N-step: two count bytes, low byte first, give K. K=0 goes to FIN directly. Otherwise go to STEP with remaining=K.
- STEP:
  - Each cycle, o_dunit_clk_en = (remaining!=0) & !i_halt. remaining decrements when clk_en=1.
  - Go to FIN when remaining reaches 0 or i_halt=1.
  - Exactly min(K, cycles before halt) enable cycles are issued. With i_halt already high, zero cycles are issued.
- RUN:
  - o_dunit_clk_en = !i_halt each cycle. Go to FIN on i_halt.
  - An accepted byte 0x58 'X' aborts: clk_en=0 from the next cycle, then go to FIN.
  - Other bytes are accepted and dropped.
- RST_PC: o_dunit_reset_pc=1 for one cycle, o_cycle_count cleared, then go to FIN.
- FIN: o_done=1 for one cycle, then go to IDLE. o_busy=0 only in IDLE.
- o_cycle_count increments on every cycle with o_dunit_clk_en=1 and saturates at all-ones. Only reset and 'R' clear it.
- o_dunit_w_mem and o_dunit_clk_en are never asserted in the same cycle.
- A reset mid-load leaves already-written words in memory. Subsequent commands start from index 0.

Test Plan:
- Load W=2 with bytes 4C 02 00 01 00 28 20 02 00 29 20 -> two single-cycle w_mem pulses: addr 0x0 data 0x20280001, then addr 0x4 data 0x20290002. Then o_done; o_busy falls.
- Load bytes 4C 01 01 (W=257, IMEM_DEPTH=256) -> o_err pulse, no w_mem, IDLE, rx_ready=1. Bytes 4C 00 00 -> o_done, no writes.
- Cmd 4E 05 00 with i_halt rising after the 3rd enabled cycle -> exactly 3 clk_en cycles, o_cycle_count=3, o_done. Then 'S' with i_halt=1 -> 0 clk_en cycles, o_done.
- Cmd 'C' with i_halt low for 20 cycles, then 'X' sent -> clk_en stops the cycle after acceptance, o_cycle_count=20 (+/- acceptance cycle, checked exactly), o_done. Then 'R' -> one reset_pc pulse, o_cycle_count=0.
- Assert i_reset mid-word (after 2 data bytes) -> all outputs 0, rx_ready=1. Then load W=1 -> write at addr 0x0 with the new word, no stale bytes.
- Unknown byte 0x7A in IDLE -> o_err pulse, no other output change.
